// File: rtl/gem_link_pkg.sv
// gem_link_pkg
// Shared definitions for the GEM trigger link:
//   - 8b/10b control and data characters used in trigger frames
//   - cluster geometry (N_CLUSTERS clusters of CLUSTER_W bits = 56-bit payload)
//   - idle word / K-flags sent while the link is not running
//   - frame-builder state enum
//   - select_kchar(): frame0 K-character priority (marker > overflow > idle comma)
package gem_link_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // plain comma
  localparam logic [7:0] K28_7 = 8'hFC;  // latency marker
  localparam logic [7:0] K23_7 = 8'hF7;  // overflow flag
  localparam logic [7:0] D16_2 = 8'h50;  // idle filler data byte

  localparam int CLUSTER_W  = 14;
  localparam int N_CLUSTERS = 4;
  localparam int PAYLOAD_W  = CLUSTER_W * N_CLUSTERS;

  localparam logic [31:0] IDLE_WORD = {D16_2, K28_5, D16_2, K28_5};
  localparam logic [3:0]  IDLE_ISK  = 4'b0101;
  localparam logic [3:0]  F0_ISK    = 4'b0001;
  localparam logic [3:0]  F1_ISK    = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // The marker wins over overflow; an overflow seen on a marker BX is carried
  // forward by the caller and reported on the next non-marker BX.
  function automatic logic [7:0] select_kchar(input logic marker, input logic ovf);
    logic [7:0] k;
    if (marker) begin
      k = K28_7;
    end else if (ovf) begin
      k = K23_7;
    end else begin
      k = K28_5;
    end
    return k;
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// prbs7_gen
// Parallel PRBS-7 (x^7 + x^6 + 1, seed 0x7F) generator presenting the next 56
// sequence bits at once. Bit 0 of data_o is the earliest bit of the sequence.
// The register jumps 56 steps ahead on each cycle with advance high.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset (reloads the seed)
//   advance  in   consume the current 56 bits and step to the next block
//   data_o   out  56-bit block of sequence bits
module prbs7_gen (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        advance,
  output logic [55:0] data_o
);

  localparam logic [6:0] SEED = 7'h7F;

  logic [6:0]  lfsr_q;
  logic [6:0]  lfsr_d;
  logic [55:0] block_s;

  // Unroll 56 LFSR steps: each step emits one bit and shifts it in.
  always_comb begin
    logic [6:0] s;
    logic       nb;
    s       = lfsr_q;
    nb      = 1'b0;
    block_s = 56'h0;
    for (int i = 0; i < 56; i++) begin
      nb         = s[6] ^ s[5];
      block_s[i] = nb;
      s          = {s[5:0], nb};
    end
    if (advance) begin
      lfsr_d = s;
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign data_o = block_s;

endmodule

// File: rtl/gem_frame_builder.sv
// gem_frame_builder
// Builds the two-word per-BX trigger frame for one GEM trigger fiber.
//   frame0 = {payload[23:0], K}  isk 0001   (K = FC marker / F7 overflow / BC)
//   frame1 = payload[55:24]      isk 0000
// An FC marker goes out every BX_PERIOD BX; overflow on a marker BX is deferred
// to the next BX so it is never lost. inj_err flips bit 0 of the next frame1.
// Optional build macro: GEM_FRAME_PRBS_EN -- compiles in a PRBS-7 payload
// source selected by ena_test_pat (sampled at phase 0). Without it,
// ena_test_pat is ignored and the payload is always gem_data.
// Ports:
//   usrclk2       in   80 MHz TX user clock, 2 cycles per BX
//   reset_n       in   async active-low reset (deassertion synchronized)
//   link_ready    in   GTX TX ready; low forces IDLE on the next edge
//   gem_data      in   {cluster3, cluster2, cluster1, cluster0}
//   gem_overflow  in   cluster overflow for this BX
//   ena_test_pat  in   send PRBS payload (only with GEM_FRAME_PRBS_EN)
//   inj_err       in   pulse: corrupt bit 0 of the next frame1
//   tx_data       out  32-bit word to GTX, byte [7:0] first
//   tx_isk        out  per-byte K flags
//   ltncy_trig    out  pulse with every FC frame0
//   strt_ltncy    out  pulse with the first FC frame0 after ALIGN
module gem_frame_builder
  import gem_link_pkg::*;
#(
  parameter int BX_PERIOD = 128
) (
  input  logic                 usrclk2,
  input  logic                 reset_n,
  input  logic                 link_ready,
  input  logic [PAYLOAD_W-1:0] gem_data,
  input  logic                 gem_overflow,
  input  logic                 ena_test_pat,
  input  logic                 inj_err,
  output logic [31:0]          tx_data,
  output logic [3:0]           tx_isk,
  output logic                 ltncy_trig,
  output logic                 strt_ltncy
);

  localparam int              CNT_W    = (BX_PERIOD > 1) ? $clog2(BX_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BX_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]           rst_sync_q;
  logic                 rst_n_s;
  logic [PAYLOAD_W-1:0] payload_s;

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [CNT_W-1:0]     bx_cnt_q, bx_cnt_d;
  logic                 first_q, first_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 err_pend_q, err_pend_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          tx_data_q, tx_data_d;
  logic [3:0]           tx_isk_q, tx_isk_d;
  logic                 ltncy_q, ltncy_d;
  logic                 strt_q, strt_d;

  logic                 marker_s;
  logic                 ovf_any_s;
  logic                 err_now_s;

  // Reset synchronizer: assert immediately, release after two clock edges.
  always_ff @(posedge usrclk2 or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

`ifdef GEM_FRAME_PRBS_EN
  logic [PAYLOAD_W-1:0] prbs_s;
  logic                 prbs_adv_s;

  // One 56-bit block per BX, consumed only when the test pattern is sent.
  assign prbs_adv_s = link_ready && (state_q == ST_RUN) && !phase_q && ena_test_pat;

  prbs7_gen u_prbs7_gen (
    .clk_i   (usrclk2),
    .rst_ni  (rst_n_s),
    .advance (prbs_adv_s),
    .data_o  (prbs_s)
  );

  assign payload_s = ena_test_pat ? prbs_s : gem_data;
`else
  logic unused_test_pat_s;
  assign unused_test_pat_s = ena_test_pat;
  assign payload_s         = gem_data;
`endif

  assign marker_s  = (bx_cnt_q == CNT_ZERO);
  assign ovf_any_s = gem_overflow | ovf_pend_q;
  // A pulse arriving in the same cycle a frame1 is built still lands on it.
  assign err_now_s = err_pend_q | inj_err;

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bx_cnt_d   = bx_cnt_q;
    first_d    = first_q;
    ovf_pend_d = ovf_pend_q;
    err_pend_d = err_now_s;
    hi_d       = hi_q;
    tx_data_d  = tx_data_q;
    tx_isk_d   = tx_isk_q;
    ltncy_d    = 1'b0;
    strt_d     = 1'b0;

    if (!link_ready) begin
      // Abandon any half-sent BX; pending error/overflow are kept.
      state_d   = ST_IDLE;
      phase_d   = 1'b0;
      tx_data_d = IDLE_WORD;
      tx_isk_d  = IDLE_ISK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ALIGN;
          tx_data_d = IDLE_WORD;
          tx_isk_d  = IDLE_ISK;
        end
        ST_ALIGN: begin
          state_d   = ST_RUN;
          phase_d   = 1'b0;
          bx_cnt_d  = CNT_ZERO;
          first_d   = 1'b1;
          tx_data_d = IDLE_WORD;
          tx_isk_d  = IDLE_ISK;
        end
        ST_RUN: begin
          if (!phase_q) begin
            hi_d      = payload_s[PAYLOAD_W-1:24];
            tx_data_d = {payload_s[23:0], select_kchar(marker_s, ovf_any_s)};
            tx_isk_d  = F0_ISK;
            phase_d   = 1'b1;
            if (marker_s) begin
              ovf_pend_d = ovf_any_s;
              ltncy_d    = 1'b1;
              strt_d     = first_q;
              first_d    = 1'b0;
            end else begin
              ovf_pend_d = 1'b0;
            end
          end else begin
            tx_data_d  = hi_q ^ {31'h0, err_now_s};
            tx_isk_d   = F1_ISK;
            err_pend_d = 1'b0;
            phase_d    = 1'b0;
            if (bx_cnt_q == CNT_LAST) begin
              bx_cnt_d = CNT_ZERO;
            end else begin
              bx_cnt_d = bx_cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          phase_d   = 1'b0;
          tx_data_d = IDLE_WORD;
          tx_isk_d  = IDLE_ISK;
        end
      endcase
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge usrclk2 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      bx_cnt_q   <= CNT_ZERO;
      first_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
      hi_q       <= 32'h0;
      tx_data_q  <= IDLE_WORD;
      tx_isk_q   <= IDLE_ISK;
      ltncy_q    <= 1'b0;
      strt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bx_cnt_q   <= bx_cnt_d;
      first_q    <= first_d;
      ovf_pend_q <= ovf_pend_d;
      err_pend_q <= err_pend_d;
      hi_q       <= hi_d;
      tx_data_q  <= tx_data_d;
      tx_isk_q   <= tx_isk_d;
      ltncy_q    <= ltncy_d;
      strt_q     <= strt_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_isk     = tx_isk_q;
  assign ltncy_trig = ltncy_q;
  assign strt_ltncy = strt_q;

endmodule

// File: tb/tb_gem_frame_builder.sv
// Self-checking bench for gem_frame_builder (default build, BX_PERIOD = 128).
// Expected output words are queued as each BX is driven and compared one
// cycle per clock edge, 1 time unit after the edge.
module tb_gem_frame_builder;

  logic        usrclk2 = 1'b0;
  logic        reset_n;
  logic        link_ready;
  logic [55:0] gem_data;
  logic        gem_overflow;
  logic        ena_test_pat;
  logic        inj_err;
  logic [31:0] tx_data;
  logic [3:0]  tx_isk;
  logic        ltncy_trig;
  logic        strt_ltncy;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  isk;
    logic        trig;
    logic        strt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side view of the frame protocol.
  int   bx       = 0;
  logic first_f  = 1'b0;
  logic ovf_pend = 1'b0;
  logic err_pend = 1'b0;

  gem_frame_builder #(.BX_PERIOD(128)) dut (
    .usrclk2      (usrclk2),
    .reset_n      (reset_n),
    .link_ready   (link_ready),
    .gem_data     (gem_data),
    .gem_overflow (gem_overflow),
    .ena_test_pat (ena_test_pat),
    .inj_err      (inj_err),
    .tx_data      (tx_data),
    .tx_isk       (tx_isk),
    .ltncy_trig   (ltncy_trig),
    .strt_ltncy   (strt_ltncy)
  );

  always #5 usrclk2 = ~usrclk2;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_idle();
    exp_t e;
    e.data = 32'h50BC50BC;
    e.isk  = 4'b0101;
    e.trig = 1'b0;
    e.strt = 1'b0;
    exp_q.push_back(e);
  endtask

  // Expected frame0 for data d with overflow ovf at the current bench BX.
  task automatic push_frame0(input logic [55:0] d, input logic ovf);
    exp_t e;
    logic [7:0] k;
    if (bx == 0) begin
      k = 8'hFC;
      if (ovf) ovf_pend = 1'b1;
    end else if (ovf || ovf_pend) begin
      k = 8'hF7;
      ovf_pend = 1'b0;
    end else begin
      k = 8'hBC;
    end
    e.data = {d[23:0], k};
    e.isk  = 4'b0001;
    e.trig = (bx == 0);
    e.strt = (bx == 0) && first_f;
    if (bx == 0) first_f = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame1(input logic [55:0] d);
    exp_t e;
    e.data = d[55:24];
    if (err_pend) e.data[0] = ~e.data[0];
    err_pend = 1'b0;
    e.isk  = 4'b0000;
    e.trig = 1'b0;
    e.strt = 1'b0;
    exp_q.push_back(e);
    bx = (bx + 1) % 128;
  endtask

  // Advance one clock and compare the DUT against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge usrclk2);
    #1;
    if (exp_q.size() == 0) begin
      check_value("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check_value("tx_data", tx_data, e.data);
      check_value("tx_isk", {28'h0, tx_isk}, {28'h0, e.isk});
      check_value("ltncy_trig", {31'h0, ltncy_trig}, {31'h0, e.trig});
      check_value("strt_ltncy", {31'h0, strt_ltncy}, {31'h0, e.strt});
    end
  endtask

  // One full BX in RUN; err_b pulses inj_err while frame0 is on the output.
  task automatic run_bx(input logic [55:0] d, input logic ovf, input logic err_b);
    gem_data     = d;
    gem_overflow = ovf;
    push_frame0(d, ovf);
    tick();
    inj_err = err_b;
    if (err_b) err_pend = 1'b1;
    push_frame1(d);
    tick();
    inj_err      = 1'b0;
    gem_overflow = 1'b0;
  endtask

  // Raise link_ready: two idle cycles (IDLE->ALIGN, ALIGN->RUN), then BX 0.
  task automatic bring_up();
    link_ready = 1'b1;
    push_idle();
    tick();
    push_idle();
    tick();
    bx      = 0;
    first_f = 1'b1;
  endtask

  initial begin
    logic [55:0] d;
    logic        ovf;
    logic        errb;

    reset_n      = 1'b0;
    link_ready   = 1'b0;
    gem_data     = 56'h0;
    gem_overflow = 1'b0;
    ena_test_pat = 1'b0;
    inj_err      = 1'b0;

    // Reset held, then released with link down: idle word throughout.
    for (int i = 0; i < 3; i++) begin
      push_idle();
      tick();
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_idle();
      tick();
    end

    // Link up; first BX carries the start marker, then 300 BX of traffic
    // with overflow on BX 50, BX 127 and the following marker BX, and an
    // injected error while the BX 200 frame0 is out.
    bring_up();
    for (int i = 0; i < 300; i++) begin
      if (i == 0) begin
        d = 56'h00123456789ABC;
      end else if (i >= 199 && i <= 203) begin
        d = 56'h0;
      end else begin
        d = {$urandom_range(16777215, 0), $urandom()};
      end
      ovf  = (i == 50) || (i == 127) || (i == 128);
      errb = (i == 200);
      run_bx(d, ovf, errb);
    end

    // Drop the link after frame0 of a BX; idle the next cycle.
    d = 56'hA5A5A5_5A5A5A5A;
    gem_data = d;
    push_frame0(d, 1'b0);
    tick();
    link_ready = 1'b0;
    push_idle();
    tick();
    // Error pulse during IDLE is held until the first RUN frame1.
    inj_err  = 1'b1;
    err_pend = 1'b1;
    push_idle();
    tick();
    inj_err = 1'b0;
    push_idle();
    tick();
    bring_up();
    run_bx(56'h00000000_111111, 1'b0, 1'b0);
    run_bx(56'h00000000_222222, 1'b0, 1'b0);
    run_bx(56'h12345678_9ABCDE, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
